// File: rtl/attention_pkg.sv
// Shared definitions for the attention MAC engine and the blocks that feed it.
//   tx_state_t : state encoding of the q/v stream transmitter
//   QV_N_ELEM  : default elements per q/v vector
//   QV_DATA_W  : default element / stream width
package attention_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } tx_state_t;

    localparam int QV_N_ELEM = 4;
    localparam int QV_DATA_W = 8;

endpackage

// File: rtl/qv_vec_buf.sv
// Two N_ELEM-deep register files (query and value) with one write port and a
// beat-indexed read mux. Beat b reads element b>>1; b[0] picks q (0) or v (1).
// Contents are not reset; they are defined once written.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe (already gated by the caller)
//   wr_sel   in   0 = q buffer, 1 = v buffer
//   wr_idx   in   element index
//   wr_data  in   element value
//   rd_beat  in   stream beat index, 0 .. 2*N_ELEM-1
//   rd_data  out  element selected by rd_beat
module qv_vec_buf
    import attention_pkg::*;
#(
    parameter int N_ELEM = QV_N_ELEM,
    parameter int DATA_W = QV_DATA_W,
    localparam int IW    = $clog2(N_ELEM),
    localparam int BW    = IW + 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BW-1:0]     rd_beat,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] q_mem [N_ELEM];
    logic [DATA_W-1:0] v_mem [N_ELEM];
    logic [IW-1:0]     rd_elem;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel)
                v_mem[wr_idx] <= wr_data;
            else
                q_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_elem = rd_beat[BW-1:1];
    assign rd_data = rd_beat[0] ? v_mem[rd_elem] : q_mem[rd_elem];

endmodule

// File: rtl/qv_stream_tx.sv
// Transmit side of the q/v byte stream into the attention MAC engine.
// Holds one query and one value vector, and on start emits them interleaved
// (q0, v0, q1, v1, ...) over a valid/ready master interface.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr_en        buffer write strobe (ignored while busy)
//   wr_sel       0 = q buffer, 1 = v buffer
//   wr_idx       element index
//   wr_data      element value
//   start        begin transmission (sampled only in IDLE)
//   busy         high in SEND and DONE
//   done         one-cycle pulse after the final beat is accepted
//   qv_mst_out   stream data
//   vld_mst_out  stream valid
//   rdy_mst_in   stream ready from the engine
module qv_stream_tx
    import attention_pkg::*;
#(
    parameter int N_ELEM = QV_N_ELEM,
    parameter int DATA_W = QV_DATA_W,
    localparam int IW    = $clog2(N_ELEM),
    localparam int BW    = IW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] qv_mst_out,
    output logic              vld_mst_out,
    input  logic              rdy_mst_in
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(2 * N_ELEM - 1);
    localparam logic [BW-1:0] ONE_BEAT  = BW'(1);

    tx_state_t     state, state_nxt;
    logic [BW-1:0] beat,  beat_nxt;
    logic          hs;

    // Outputs decode directly from state, so a reset edge drops valid at once.
    assign vld_mst_out = (state == SEND);
    assign done        = (state == DONE);
    assign busy        = (state != IDLE);
    assign hs          = vld_mst_out & rdy_mst_in;

    // Buffer is frozen while busy so the presented beat cannot change under a stall.
    qv_vec_buf #(
        .N_ELEM (N_ELEM),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en & ~busy),
        .wr_sel  (wr_sel),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_beat (beat),
        .rd_data (qv_mst_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        unique case (state)
            IDLE: begin
                beat_nxt = '0;
                if (start)
                    state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (beat == LAST_BEAT) begin
                        state_nxt = DONE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + ONE_BEAT;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_qv_stream_tx.sv
module tb_qv_stream_tx;

    localparam int N_ELEM = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic              wr_sel;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] qv_mst_out;
    logic              vld_mst_out;
    logic              rdy_mst_in;

    int checks = 0;
    int errors = 0;

    // Expected interleaved stream for q={1,2,3,4}, v={5,6,7,8}
    logic [7:0] exp_seq [8] = '{8'h01, 8'h05, 8'h02, 8'h06, 8'h03, 8'h07, 8'h04, 8'h08};

    qv_stream_tx #(.N_ELEM(N_ELEM), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .qv_mst_out  (qv_mst_out),
        .vld_mst_out (vld_mst_out),
        .rdy_mst_in  (rdy_mst_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input logic sel, input logic [1:0] idx, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_vectors();
        for (int i = 0; i < N_ELEM; i++) write_elem(1'b0, 2'(i), 8'(i + 1));
        for (int i = 0; i < N_ELEM; i++) write_elem(1'b1, 2'(i), 8'(i + 5));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (vld_mst_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state vld=%b busy=%b done=%b want 0 0 0", vld_mst_out, busy, done);
        end
    endtask

    task automatic test_basic();
        rdy_mst_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (vld_mst_out !== 1'b1 || qv_mst_out !== exp_seq[b] || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d vld=%b data=%h done=%b want 1 %h 0",
                         b, vld_mst_out, qv_mst_out, done, exp_seq[b]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || vld_mst_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b busy=%b vld=%b want 1 1 0", done, busy, vld_mst_out);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || vld_mst_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle done=%b busy=%b vld=%b want 0 0 0", done, busy, vld_mst_out);
        end
    endtask

    task automatic test_backpressure();
        int hs_cnt;
        hs_cnt = 0;
        rdy_mst_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && hs_cnt < 8; cyc++) begin
            rdy_mst_in = (cyc % 3 == 0);
            checks++;
            if (vld_mst_out !== 1'b1 || qv_mst_out !== exp_seq[hs_cnt]) begin
                errors++;
                $display("FAIL bp_cycle%0d vld=%b data=%h want 1 %h",
                         cyc, vld_mst_out, qv_mst_out, exp_seq[hs_cnt]);
            end
            if (rdy_mst_in) hs_cnt++;
            tick();
        end
        rdy_mst_in = 1'b1;
        checks++;
        if (hs_cnt !== 8 || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done handshakes=%0d done=%b want 8 1", hs_cnt, done);
        end
        tick();
    endtask

    task automatic test_ignored();
        rdy_mst_in = 1'b1;
        start = 1'b1;
        tick();
        // In SEND: attempt a write to q[0] and a second start
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = 8'hFF;
        start = 1'b1;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (vld_mst_out !== 1'b1 || qv_mst_out !== exp_seq[b]) begin
                errors++;
                $display("FAIL ign_beat%0d vld=%b data=%h want 1 %h",
                         b, vld_mst_out, qv_mst_out, exp_seq[b]);
            end
            tick();
            wr_en = 1'b0;
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ign_done done=%b want 1", done);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || vld_mst_out !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_restart busy=%b vld=%b want 0 0", busy, vld_mst_out);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (vld_mst_out !== 1'b1 || qv_mst_out !== 8'h01) begin
            errors++;
            $display("FAIL ign_restart vld=%b data=%h want 1 01", vld_mst_out, qv_mst_out);
        end
        for (int b = 0; b < 9; b++) tick();
    endtask

    task automatic test_reset_mid();
        rdy_mst_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 3; b++) tick();
        checks++;
        if (qv_mst_out !== 8'h06 || vld_mst_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_beat3 vld=%b data=%h want 1 06", vld_mst_out, qv_mst_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (vld_mst_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after vld=%b done=%b busy=%b want 0 0 0", vld_mst_out, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_nodone done=%b want 0", done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (vld_mst_out !== 1'b1 || qv_mst_out !== 8'h01) begin
            errors++;
            $display("FAIL rst_mid_restart vld=%b data=%h want 1 01", vld_mst_out, qv_mst_out);
        end
        for (int b = 0; b < 9; b++) tick();
    endtask

    task automatic test_same_cycle();
        rdy_mst_in = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = 8'hA5;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        checks++;
        if (vld_mst_out !== 1'b1 || qv_mst_out !== 8'hA5) begin
            errors++;
            $display("FAIL same_cycle vld=%b data=%h want 1 a5", vld_mst_out, qv_mst_out);
        end
        tick();
        checks++;
        if (qv_mst_out !== 8'h05) begin
            errors++;
            $display("FAIL same_cycle_beat1 data=%h want 05", qv_mst_out);
        end
        for (int b = 0; b < 8; b++) tick();
        write_elem(1'b0, 2'd0, 8'h01);
    endtask

    task automatic test_final_stall();
        rdy_mst_in = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 7; b++) tick();
        rdy_mst_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (vld_mst_out !== 1'b1 || qv_mst_out !== 8'h08 || done !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d vld=%b data=%h done=%b want 1 08 0",
                         c, vld_mst_out, qv_mst_out, done);
            end
            tick();
        end
        rdy_mst_in = 1'b1;
        checks++;
        if (vld_mst_out !== 1'b1 || qv_mst_out !== 8'h08) begin
            errors++;
            $display("FAIL stall_release vld=%b data=%h want 1 08", vld_mst_out, qv_mst_out);
        end
        tick();
        checks++;
        if (done !== 1'b1 || vld_mst_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_done done=%b vld=%b want 1 0", done, vld_mst_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_sel = 1'b0;
        wr_idx = '0;
        wr_data = '0;
        start = 1'b0;
        rdy_mst_in = 1'b0;
        #1;
        test_reset();
        load_vectors();
        checks++;
        if (qv_mst_out !== 8'h01) begin
            errors++;
            $display("FAIL idle_mux data=%h want 01", qv_mst_out);
        end
        test_basic();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        test_same_cycle();
        test_final_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qv_stream_tx.md
Name: qv_stream_tx

Overview:
- Transmit side of the q/v byte stream consumed by the attention MAC engine.
- Holds one query vector and one value vector of N_ELEM bytes, loaded through a simple write port.
- On start, emits the 2*N_ELEM bytes interleaved (q0, v0, q1, v1, ...) over a valid/ready master interface.
- Sits between the host/config logic and the engine's qv slave port.

Parameters:
- N_ELEM, 4, elements per vector; power of two, at least 2.
- DATA_W, 8, width of each element and of the stream bus.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  buffer write strobe.
- wr_sel  input  1  0 = write q buffer, 1 = write v buffer.
- wr_idx  input  $clog2(N_ELEM)  element index.
- wr_data  input  DATA_W  element value.
- start  input  1  begin transmission; sampled only in IDLE.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the final beat is accepted.
- qv_mst_out  output  DATA_W  stream data.
- vld_mst_out  output  1  stream valid.
- rdy_mst_in  input  1  stream ready from the engine.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, beat counter=0, vld_mst_out=0, done=0, busy=0. Buffer contents are not reset (undefined until written).
- Reset mid-transfer: vld_mst_out low the cycle after the reset edge; no done pulse is emitted.
- States:
  - IDLE: vld=0, busy=0. If start=1, go to SEND with beat=0.
  - SEND: vld=1, busy=1.
    - Handshake when vld_mst_out & rdy_mst_in at a rising edge.
    - On handshake with beat < 2*N_ELEM-1: beat increments.
    - On handshake with beat = 2*N_ELEM-1: go to DONE, vld=0 next cycle.
    - No handshake: hold state and beat.
  - DONE: done=1, busy=1, vld=0 for exactly one cycle, then IDLE.
- Beat mapping: beat b selects element b>>1; b[0]=0 selects q, b[0]=1 selects v. qv_mst_out is muxed from the buffer by beat.
- Back-to-back rate: one beat per cycle while rdy_mst_in=1. A full transfer takes 2*N_ELEM cycles in SEND plus 1 cycle in DONE.
- Stability: while vld_mst_out=1 and not accepted, qv_mst_out must not change. The buffer is frozen while busy: wr_en is ignored in SEND and DONE.
- rdy_mst_in is ignored while vld_mst_out=0.
- start is ignored while busy (no queuing).
- wr_en and start in the same IDLE cycle: the write commits at that edge, and the first beat reflects the new value.
- qv_mst_out value while vld=0 is don't-care, but must be a deterministic buffer mux output, never X after all elements have been written.
- Latency: start at edge k gives vld_mst_out=1 from cycle k+1.
- Ready may drop at any cycle, including on the final beat. The final beat then stays presented until accepted.

Decomposition:
- attention_pkg holds:
  - tx_state_t enum, 2 bits: IDLE=2'b00, SEND=2'b01, DONE=2'b10.
  - Default N_ELEM and DATA_W localparams shared with the engine.
- One sub-module is natural: qv_vec_buf, a 2xN_ELEM register file with write port and beat-indexed read mux. The FSM and beat counter stay in qv_stream_tx.

Test Plan:
1. Basic transfer: write q={1,2,3,4}, v={5,6,7,8}; start with rdy held high -> bytes 1,5,2,6,3,7,4,8 on consecutive cycles; done pulses one cycle after byte 8; busy low the following cycle.
2. Backpressure: same data, rdy toggles 1,0,0,1,... -> each byte held stable while rdy=0; order unchanged; 8 handshakes total.
3. Ignored writes and start: during SEND, write q[0]=0xFF and assert start -> stream unchanged (0x01 first); no second transfer. A following idle-time start sends 0x01 again.
4. Reset mid-stream: assert rst after 3 handshakes -> vld low next cycle, no done pulse. A new start sends from q[0] again.
5. Same-cycle write and start: in IDLE, write q[0]=0xA5 with start=1 -> first beat is 0xA5.
6. Final-beat stall: rdy=0 when beat 7 is presented, for 5 cycles -> 0x08 held for 5 cycles; done only after rdy rises and the beat is accepted.
